// File: rtl/mem_responder_pkg.sv
// Shared definitions for the mem_responder slice: data-path widths,
// the wait-counter bound and the access FSM state encoding.
package mem_responder_pkg;

  localparam int BYTE_W   = 8;
  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 15;

  // Wide enough to hold any legal WAIT_CYCLES-1 value.
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_byte_array.sv
// 256 x 8 byte storage with a 4-byte big-endian word view.
// The byte at addr maps to the most significant lane. Lane addresses
// wrap modulo the array depth, so a word at 0xFE covers 0xFE,0xFF,0x00,0x01.
module mem_byte_array
  import mem_responder_pkg::*;
(
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int LANES = DATA_W / BYTE_W;

  logic [BYTE_W-1:0] mem [DEPTH];

  // Combinational word read: assemble four consecutive bytes, big-endian.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    rd_data = '0;
    for (int i = 0; i < LANES; i++) begin
      rd_data[DATA_W-1-i*BYTE_W -: BYTE_W] = mem[addr + ADDR_W'(i)];
    end
  end

  // Word write: commit all four lanes on one clock edge.
  // NOTE: the storage array has no reset; contents survive a reset and a RAM macro can be inferred.
  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        mem[addr + ADDR_W'(i)] <= wr_data[DATA_W-1-i*BYTE_W -: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Simple memory responder: accepts a read or write request in IDLE,
// waits WAIT_CYCLES cycles, then completes with a one-cycle mem_ready.
// Reads load read_data and writes commit storage on the edge entering RESP.
// Optional build macro: MEM_RESPONDER_ALIGN_CHECK_EN -- when defined,
// accesses with address[1:0] != 0 complete with mem_err and touch nothing.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              mem_ready,
  output logic              mem_err
);

  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_t            state, next_state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_read, lat_write, lat_err;

  logic              req;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic              cur_read, cur_write, cur_err;
  logic              enter_resp;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  assign req = mem_read | mem_write;

  // Next-state logic: IDLE -> WAIT/RESP on a request, WAIT counts down, RESP lasts one cycle.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (req) next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (cnt == '0) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request view for the edge entering RESP: live inputs when accepting
  // straight from IDLE (zero-wait case), latched copies otherwise.
  always_comb begin
    cur_addr  = lat_addr;
    cur_wdata = lat_wdata;
    cur_read  = lat_read;
    cur_write = lat_write;
    if (state == IDLE) begin
      cur_addr  = address;
      cur_wdata = write_data;
      cur_read  = mem_read;
      cur_write = mem_write;
    end
  end

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  assign cur_err = (cur_read & cur_write) | (cur_addr[1:0] != 2'b00);
`else
  assign cur_err = cur_read & cur_write;
`endif

  assign enter_resp = (next_state == RESP);
  // Gated by reset so a request held during reset never writes storage.
  assign mem_we     = enter_resp & cur_write & ~cur_err & reset;

  // FSM state, wait counter and request latches.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_read  <= 1'b0;
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      state <= next_state;
      if (state == IDLE && req) begin
        cnt       <= CNT_LOAD;
        lat_addr  <= address;
        lat_wdata <= write_data;
        lat_read  <= mem_read;
        lat_write <= mem_write;
        lat_err   <= cur_err;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Load data register: updated only by a successful read entering RESP.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      read_data <= '0;
    end else if (enter_resp && cur_read && !cur_err) begin
      read_data <= mem_rdata;
    end
  end

  assign mem_ready = (state == RESP);
  assign mem_err   = mem_ready & lat_err;

  mem_byte_array u_array (
    .clock   (clock),
    .we      (mem_we),
    .addr    (cur_addr),
    .wr_data (cur_wdata),
    .rd_data (mem_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a WAIT_CYCLES=2 instance driven
// by directed and random accesses against a byte-array reference model,
// plus a WAIT_CYCLES=0 instance exercising continuously held requests.
// Honours MEM_RESPONDER_ALIGN_CHECK_EN in its expectations.
module tb_mem_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        rd, wr;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready, err;

  logic        rd0, wr0;
  logic [7:0]  addr0;
  logic [31:0] wdata0;
  logic [31:0] rdata0;
  logic        ready0, err0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int prev_accept = 0;
  bit prev_valid = 1'b0;

  logic [7:0]  ref_mem [256];
  logic [31:0] exp_rdata = 32'h0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  mem_responder #(.WAIT_CYCLES(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .mem_read   (rd),
    .mem_write  (wr),
    .address    (addr),
    .write_data (wdata),
    .read_data  (rdata),
    .mem_ready  (ready),
    .mem_err    (err)
  );

  mem_responder #(.WAIT_CYCLES(0)) dut0 (
    .clock      (clock),
    .reset      (reset),
    .mem_read   (rd0),
    .mem_write  (wr0),
    .address    (addr0),
    .write_data (wdata0),
    .read_data  (rdata0),
    .mem_ready  (ready0),
    .mem_err    (err0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [7:0] a);
    return {ref_mem[a], ref_mem[a + 8'd1], ref_mem[a + 8'd2], ref_mem[a + 8'd3]};
  endfunction

  function automatic logic ref_error(input logic r, input logic w, input logic [7:0] a);
    logic e;
    e = r & w;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    e = e | (a[1:0] != 2'b00);
`endif
    return e;
  endfunction

  // One complete access on the WAIT_CYCLES=2 instance. Called at a falling
  // edge with the DUT idle; returns at a falling edge with the DUT idle.
  task automatic do_access(input logic r, input logic w, input logic [7:0] a,
                           input logic [31:0] d, input string tag);
    logic exp_err;
    int   lat;
    exp_err = ref_error(r, w, a);
    rd = r; wr = w; addr = a; wdata = d;
    @(posedge clock); #1;
    if (prev_valid) check({tag, "_rate"}, 32'(cyc - prev_accept), 32'd4);
    prev_accept = cyc;
    prev_valid  = 1'b1;
    if (!exp_err) begin
      if (w) for (int i = 0; i < 4; i++) ref_mem[a + 8'(i)] = d[31-8*i -: 8];
      if (r) exp_rdata = ref_word(a);
    end
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (ready === 1'b1) begin
        lat = k;
        break;
      end
      // Inputs must be ignored once the request is accepted.
      addr  = 8'($urandom);
      wdata = $urandom;
    end
    check({tag, "_lat"}, 32'(lat), 32'd3);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_rdata"}, rdata, exp_rdata);
    rd = 1'b0; wr = 1'b0;
    @(negedge clock);
    check({tag, "_pulse"}, 32'(ready), 32'd0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rd = 0; wr = 0; addr = 0; wdata = 0;
    rd0 = 0; wr0 = 0; addr0 = 0; wdata0 = 0;

    // Asynchronous reset before any clock edge.
    #2 reset = 1'b0;
    #1;
    check("rst_rdata", rdata, 32'h0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready0", 32'(ready0), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Preload every byte so the model is fully defined.
    for (int i = 0; i < 64; i++) do_access(1'b0, 1'b1, 8'(i * 4), $urandom, "preload");

    // Write then read back at 0x10.
    do_access(1'b0, 1'b1, 8'h10, 32'hDEADBEEF, "w10");
    do_access(1'b1, 1'b0, 8'h10, 32'h0, "r10");
    check("r10_value", rdata, 32'hDEADBEEF);

    // Unaligned read spanning a word boundary.
    do_access(1'b0, 1'b1, 8'h20, 32'h11223344, "w20");
    do_access(1'b1, 1'b0, 8'h21, 32'h0, "r21");
`ifndef MEM_RESPONDER_ALIGN_CHECK_EN
    check("r21_value", rdata, 32'h22334400 | {24'h0, ref_mem[8'h24]});
`endif

    // Read and write both asserted: error, nothing touched.
    do_access(1'b1, 1'b1, 8'h30, 32'hAAAAAAAA, "both30");
    do_access(1'b1, 1'b0, 8'h30, 32'h0, "r30");

    // Wrap-around write at 0xFE.
    do_access(1'b0, 1'b1, 8'hFE, 32'hCAFEF00D, "wfe");
    do_access(1'b1, 1'b0, 8'hFE, 32'h0, "rfe");
    do_access(1'b1, 1'b0, 8'h00, 32'h0, "r00");
`ifndef MEM_RESPONDER_ALIGN_CHECK_EN
    check("wrap_low", {16'h0, rdata[31:16]}, 32'h0000F00D);
`endif

    // Reset in the middle of a write aborts it.
    rd = 1'b0; wr = 1'b1; addr = 8'h40; wdata = 32'h55555555;
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    check("abort_rdata", rdata, 32'h0);
    check("abort_ready", 32'(ready), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    wr = 1'b0;
    exp_rdata  = 32'h0;
    prev_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    do_access(1'b1, 1'b0, 8'h40, 32'h0, "r40");

    // Random traffic.
    for (int n = 0; n < 150; n++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel == 0)      do_access(1'b1, 1'b1, 8'($urandom), $urandom, "rnd_both");
      else if (sel < 5)  do_access(1'b0, 1'b1, 8'($urandom), $urandom, "rnd_wr");
      else               do_access(1'b1, 1'b0, 8'($urandom), $urandom, "rnd_rd");
    end

    // Zero-wait instance with requests held continuously.
    @(negedge clock);
    wr0 = 1'b1; addr0 = 8'h08; wdata0 = 32'h0BADF00D;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      check("w0_ready", 32'(ready0), 32'(k % 2));
    end
    wr0 = 1'b0; rd0 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      check("r0_ready", 32'(ready0), 32'(k % 2));
      if (k % 2 == 1) begin
        check("r0_rdata", rdata0, 32'h0BADF00D);
        check("r0_err", 32'(err0), 32'd0);
      end
    end
    rd0 = 1'b0;
    @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
